// File: rtl/shift_operand_loader.sv
// Serial-to-parallel operand loader: N_CH channels shift into DEPTH-bit words that are handed
// off through a one-entry valid/ready buffer. Define SHIFT_LOADER_PARITY_EN to add dst_parity.
module shift_operand_loader #(
  parameter int N_CH  = 25,
  parameter int DEPTH = 25,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         src_in,
  input  logic                    shift_en,
  output logic                    in_ready,
  input  logic                    clear,
  output logic [N_CH*DEPTH-1:0]   dst_data,
  output logic                    dst_valid,
  input  logic                    dst_ready,
  output logic [CNT_W-1:0]        word_cnt,
`ifdef SHIFT_LOADER_PARITY_EN
  output logic [N_CH-1:0]         dst_parity,
`endif
  output logic                    overrun
);

  localparam int BC_W = $clog2(DEPTH);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DEPTH - 1);

  logic [N_CH*DEPTH-1:0] r_sh;
  logic [BC_W-1:0]       r_bit_cnt;
  logic                  r_overrun;
  logic [N_CH*DEPTH-1:0] r_dst_data;
  logic                  r_dst_valid;
  logic [CNT_W-1:0]      r_word_cnt;

  logic [N_CH*DEPTH-1:0] w_sh_next;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_complete;

`ifdef SHIFT_LOADER_PARITY_EN
  logic [N_CH-1:0]       r_dst_parity;

  function automatic logic [N_CH-1:0] word_parity(input logic [N_CH*DEPTH-1:0] data);
    logic [N_CH-1:0] par;
    par = '0;
    for (int c = 0; c < N_CH; c++) begin
      par[c] = ^data[c*DEPTH +: DEPTH];
    end
    return par;
  endfunction

  assign dst_parity = r_dst_parity;
`endif

  // Next shift-register value: every channel moves up one bit, newest bit at the LSB
  always_comb begin
    w_sh_next = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_sh_next[c*DEPTH +: DEPTH] = {r_sh[c*DEPTH +: DEPTH-1], src_in[c]};
    end
  end

  // Only the word-completing bit can stall, and only while the buffer is still occupied
  assign w_last     = (r_bit_cnt == LAST_BIT);
  assign in_ready   = !(w_last && r_dst_valid && !dst_ready);
  assign w_accept   = shift_en && in_ready && !clear;
  assign w_complete = w_accept && w_last;

  // Shift registers, bit counter and sticky overrun; clear beats any simultaneous shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh      <= '0;
      r_bit_cnt <= '0;
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_sh      <= '0;
      r_bit_cnt <= '0;
      r_overrun <= 1'b0;
    end else if (shift_en && !in_ready) begin
      r_overrun <= 1'b1;
    end else if (w_accept) begin
      r_sh      <= w_sh_next;
      r_bit_cnt <= w_last ? '0 : r_bit_cnt + BC_W'(1);
    end
  end

  // Output buffer: a completing word reloads it even while draining, so words run back to back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dst_data   <= '0;
      r_dst_valid  <= 1'b0;
      r_word_cnt   <= '0;
`ifdef SHIFT_LOADER_PARITY_EN
      r_dst_parity <= '0;
`endif
    end else if (w_complete) begin
      r_dst_data   <= w_sh_next;
      r_dst_valid  <= 1'b1;
      r_word_cnt   <= r_word_cnt + CNT_W'(1);
`ifdef SHIFT_LOADER_PARITY_EN
      r_dst_parity <= word_parity(w_sh_next);
`endif
    end else if (r_dst_valid && dst_ready) begin
      r_dst_valid  <= 1'b0;
    end
  end

  assign dst_data  = r_dst_data;
  assign dst_valid = r_dst_valid;
  assign word_cnt  = r_word_cnt;
  assign overrun   = r_overrun;

endmodule
